// File: rtl/numled_scan_ctrl.sv
// numled_scan_ctrl: bus-side controller for the 8-digit seven-segment display.
// Holds the display value and control bits, runs the scan-clock divider and the
// SHOW/DARK blink sequencer, and merges keyboard hex-digit echo into DATA.
// Optional build macro NUMLED_SCAN_CTRL_READBACK_EN enables registered register
// readback on bus_rdata; without it bus_rdata is tied to zero.
module numled_scan_ctrl #(
  parameter int CLK_DIV   = 50000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic        kb_valid,
  input  logic [3:0]  kb_code,
  output logic        kb_ready,
  output logic        scan_clk,
  output logic        disp_light,
  output logic [31:0] disp_num
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SHOW = 2'b01,
    DARK = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic [BLK_W-1:0] blink_cnt;
  logic [BLK_W-1:0] blink_cnt_nxt;
  logic [31:0]      data;
  logic             en;
  logic             blink;
  logic             kb_echo;
  logic             data_we;
  logic             ctrl_we;

  // A CPU write to DATA always beats the keyboard; the digit simply waits.
  assign data_we  = bus_we & (bus_addr == 2'd0);
  assign ctrl_we  = bus_we & (bus_addr == 2'd1);
  assign kb_ready = kb_echo & ~data_we;
  assign disp_num = data;

  // DATA and CTRL registers; keyboard digits shift in from the right.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      en      <= 1'b0;
      blink   <= 1'b0;
      kb_echo <= 1'b0;
    end else begin
      if (data_we)
        data <= bus_wdata;
      else if (kb_valid && kb_ready)
        data <= {data[27:0], kb_code};
      if (ctrl_we) begin
        en      <= bus_wdata[0];
        blink   <= bus_wdata[1];
        kb_echo <= bus_wdata[2];
      end
    end
  end

  // Free-running scan divider; it keeps toggling even while the display is dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      scan_clk <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt  <= '0;
      scan_clk <= ~scan_clk;
    end else begin
      div_cnt  <= div_cnt + DIV_W'(1);
    end
  end

  // Sequencer state, blink counter and the registered light enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      blink_cnt  <= '0;
      disp_light <= 1'b0;
    end else begin
      state      <= state_nxt;
      blink_cnt  <= blink_cnt_nxt;
      disp_light <= (state == SHOW);
    end
  end

  // Next-state logic; EN=0 overrides any blink transition.
  always_comb begin
    state_nxt     = state;
    blink_cnt_nxt = blink_cnt;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt     = SHOW;
          blink_cnt_nxt = '0;
        end
      end
      SHOW: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (!blink) begin
          blink_cnt_nxt = '0;
        end else if (blink_cnt == BLK_LAST) begin
          state_nxt     = DARK;
          blink_cnt_nxt = '0;
        end else begin
          blink_cnt_nxt = blink_cnt + BLK_W'(1);
        end
      end
      DARK: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (!blink || (blink_cnt == BLK_LAST)) begin
          state_nxt     = SHOW;
          blink_cnt_nxt = '0;
        end else begin
          blink_cnt_nxt = blink_cnt + BLK_W'(1);
        end
      end
      default: begin
        state_nxt     = IDLE;
        blink_cnt_nxt = '0;
      end
    endcase
  end

`ifdef NUMLED_SCAN_CTRL_READBACK_EN
  logic [31:0] status;
  assign status = {28'd0, 2'(state), kb_valid & ~kb_ready, disp_light};

  // Registered readback; the last read value is held until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_rdata <= '0;
    end else if (bus_re) begin
      case (bus_addr)
        2'd0:    bus_rdata <= data;
        2'd1:    bus_rdata <= {29'd0, kb_echo, blink, en};
        2'd2:    bus_rdata <= status;
        default: bus_rdata <= '0;
      endcase
    end
  end
`else
  logic unused_re;
  assign unused_re = bus_re;
  assign bus_rdata = '0;
`endif

endmodule

// File: tb/tb_numled_scan_ctrl.sv
// Self-checking bench for numled_scan_ctrl with CLK_DIV=4, BLINK_DIV=10.
module tb_numled_scan_ctrl;
  localparam int CLK_DIV   = 4;
  localparam int BLINK_DIV = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [1:0]  bus_addr = 2'd0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        kb_valid = 1'b0;
  logic [3:0]  kb_code = 4'd0;
  logic        kb_ready;
  logic        scan_clk;
  logic        disp_light;
  logic [31:0] disp_num;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_data = '0;

  always #5 clk = ~clk;

  numled_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .bus_we(bus_we), .bus_re(bus_re),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .kb_valid(kb_valid), .kb_code(kb_code), .kb_ready(kb_ready),
    .scan_clk(scan_clk), .disp_light(disp_light), .disp_num(disp_num)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached (%0d checks so far)", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    tick();
    bus_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++; if (disp_light !== 1'b0) begin n_fail++; $display("FAIL reset_light: got %b expected 0", disp_light); end
    n_checks++; if (disp_num !== 32'd0) begin n_fail++; $display("FAIL reset_num: got %h expected 0", disp_num); end
    n_checks++; if (scan_clk !== 1'b0) begin n_fail++; $display("FAIL reset_scan: got %b expected 0", scan_clk); end
    n_checks++; if (bus_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus_rdata); end
    n_checks++; if (kb_ready !== 1'b0) begin n_fail++; $display("FAIL reset_kb_ready: got %b expected 0", kb_ready); end
    rst_n = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      tick();
      n_checks++;
      if (scan_clk !== 1'((n / CLK_DIV) % 2)) begin
        n_fail++; $display("FAIL scan_clk cycle %0d: got %b expected %0d", n, scan_clk, (n / CLK_DIV) % 2);
      end
      n_checks++; if (disp_light !== 1'b0) begin n_fail++; $display("FAIL idle_light cycle %0d: got %b expected 0", n, disp_light); end
    end
    n_checks++; if (disp_num !== 32'd0) begin n_fail++; $display("FAIL idle_num: got %h expected 0", disp_num); end
  endtask

  task automatic test_data_en();
    bus_write(2'd0, 32'h1234ABCD);
    m_data = 32'h1234ABCD;
    n_checks++; if (disp_num !== m_data) begin n_fail++; $display("FAIL data_write: got %h expected %h", disp_num, m_data); end
    kb_valid = 1'b1; kb_code = 4'hF;
    bus_write(2'd1, 32'h1);
    n_checks++; if (kb_ready !== 1'b0) begin n_fail++; $display("FAIL kb_ready_no_echo: got %b expected 0", kb_ready); end
    n_checks++; if (disp_light !== 1'b0) begin n_fail++; $display("FAIL light_lat0: got %b expected 0", disp_light); end
    tick();
    n_checks++; if (disp_light !== 1'b0) begin n_fail++; $display("FAIL light_lat1: got %b expected 0", disp_light); end
    tick();
    n_checks++; if (disp_light !== 1'b1) begin n_fail++; $display("FAIL light_lat2: got %b expected 1", disp_light); end
    kb_valid = 1'b0;
    n_checks++; if (disp_num !== m_data) begin n_fail++; $display("FAIL data_no_echo: got %h expected %h", disp_num, m_data); end
  endtask

  task automatic test_blink();
    int k;
    k = 0;
    bus_write(2'd1, 32'h3);
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (disp_light === 1'b0) begin k = i; break; end
    end
    n_checks++; if (k != BLINK_DIV + 1) begin n_fail++; $display("FAIL blink_first_fall: got cycle %0d expected %0d", k, BLINK_DIV + 1); end
    for (int j = 1; j < BLINK_DIV; j++) begin
      tick();
      n_checks++; if (disp_light !== 1'b0) begin n_fail++; $display("FAIL blink_dark %0d: got %b expected 0", j, disp_light); end
    end
    for (int j = 0; j < BLINK_DIV; j++) begin
      tick();
      n_checks++; if (disp_light !== 1'b1) begin n_fail++; $display("FAIL blink_show %0d: got %b expected 1", j, disp_light); end
    end
    tick();
    n_checks++; if (disp_light !== 1'b0) begin n_fail++; $display("FAIL blink_second_fall: got %b expected 0", disp_light); end
    bus_write(2'd1, 32'h1);
    tick();
    tick();
    n_checks++; if (disp_light !== 1'b1) begin n_fail++; $display("FAIL unblink_light: got %b expected 1", disp_light); end
    for (int j = 0; j < 2 * BLINK_DIV; j++) begin
      tick();
      n_checks++; if (disp_light !== 1'b1) begin n_fail++; $display("FAIL steady_light %0d: got %b expected 1", j, disp_light); end
    end
  endtask

  task automatic test_kb();
    bus_write(2'd1, 32'h5);
    bus_write(2'd0, 32'h0);
    kb_valid = 1'b1; kb_code = 4'hA;
    #1;
    n_checks++; if (kb_ready !== 1'b1) begin n_fail++; $display("FAIL kb_ready_a: got %b expected 1", kb_ready); end
    tick();
    kb_code = 4'h3;
    #1;
    n_checks++; if (disp_num !== 32'h0000000A) begin n_fail++; $display("FAIL kb_data_a: got %h expected 0000000a", disp_num); end
    n_checks++; if (kb_ready !== 1'b1) begin n_fail++; $display("FAIL kb_ready_3: got %b expected 1", kb_ready); end
    tick();
    kb_valid = 1'b0;
    n_checks++; if (disp_num !== 32'h000000A3) begin n_fail++; $display("FAIL kb_data_a3: got %h expected 000000a3", disp_num); end
  endtask

  task automatic test_collision();
    kb_valid = 1'b1; kb_code = 4'h7;
    bus_we = 1'b1; bus_addr = 2'd0; bus_wdata = 32'h55;
    #1;
    n_checks++; if (kb_ready !== 1'b0) begin n_fail++; $display("FAIL coll_ready: got %b expected 0", kb_ready); end
    tick();
    bus_we = 1'b0;
    n_checks++; if (disp_num !== 32'h55) begin n_fail++; $display("FAIL coll_cpu_wins: got %h expected 00000055", disp_num); end
    #1;
    n_checks++; if (kb_ready !== 1'b1) begin n_fail++; $display("FAIL coll_ready_next: got %b expected 1", kb_ready); end
    tick();
    kb_valid = 1'b0;
    n_checks++; if (disp_num !== 32'h557) begin n_fail++; $display("FAIL coll_kb_after: got %h expected 00000557", disp_num); end
    m_data = 32'h557;
  endtask

  // Random mix of CPU writes, CTRL changes and keyboard digits against a value model.
  task automatic test_random();
    logic m_echo;
    logic we;
    logic [1:0] a;
    logic [31:0] wd;
    logic kv;
    logic [3:0] kc;
    logic exp_ready;
    m_echo = 1'b1;
    for (int i = 0; i < 200; i++) begin
      we = ($urandom_range(0, 2) == 0);
      a  = 2'($urandom_range(0, 3));
      wd = $urandom;
      kv = 1'($urandom_range(0, 1));
      kc = 4'($urandom_range(0, 15));
      if (a == 2'd1 && $urandom_range(0, 3) != 0) wd[2] = 1'b1;
      bus_we = we; bus_addr = a; bus_wdata = wd; kb_valid = kv; kb_code = kc;
      #1;
      exp_ready = m_echo && !(we && a == 2'd0);
      n_checks++; if (kb_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready %0d: got %b expected %b", i, kb_ready, exp_ready); end
      if (we && a == 2'd0) m_data = wd;
      else if (kv && exp_ready) m_data = (m_data << 4) | 32'(kc);
      if (we && a == 2'd1) m_echo = wd[2];
      tick();
      n_checks++; if (disp_num !== m_data) begin n_fail++; $display("FAIL rnd_data %0d: got %h expected %h", i, disp_num, m_data); end
    end
    bus_we = 1'b0; kb_valid = 1'b0;
  endtask

  task automatic test_readback();
    int got_dark;
    got_dark = 0;
    bus_write(2'd1, 32'h1);
    repeat (3) tick();
    bus_write(2'd1, 32'h3);
    bus_re = 1'b1; bus_addr = 2'd1;
    tick();
    bus_re = 1'b0;
`ifdef NUMLED_SCAN_CTRL_READBACK_EN
    n_checks++; if (bus_rdata !== 32'h3) begin n_fail++; $display("FAIL rd_ctrl: got %h expected 00000003", bus_rdata); end
    tick();
    n_checks++; if (bus_rdata !== 32'h3) begin n_fail++; $display("FAIL rd_hold: got %h expected 00000003", bus_rdata); end
`else
    n_checks++; if (bus_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_off_ctrl: got %h expected 0", bus_rdata); end
`endif
    for (int i = 0; i < 40; i++) begin
      tick();
      if (disp_light === 1'b0) begin got_dark = 1; break; end
    end
    n_checks++; if (got_dark != 1) begin n_fail++; $display("FAIL rd_wait_dark: got no dark phase within 40 cycles, expected one"); end
    bus_re = 1'b1; bus_addr = 2'd2;
    tick();
`ifdef NUMLED_SCAN_CTRL_READBACK_EN
    n_checks++; if (bus_rdata !== 32'h8) begin n_fail++; $display("FAIL rd_status_dark: got %h expected 00000008", bus_rdata); end
`else
    n_checks++; if (bus_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_off_status: got %h expected 0", bus_rdata); end
`endif
    bus_addr = 2'd3;
    tick();
    n_checks++; if (bus_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_addr3: got %h expected 0", bus_rdata); end
    bus_addr = 2'd0;
    tick();
    bus_re = 1'b0;
`ifdef NUMLED_SCAN_CTRL_READBACK_EN
    n_checks++; if (bus_rdata !== m_data) begin n_fail++; $display("FAIL rd_data: got %h expected %h", bus_rdata, m_data); end
`else
    n_checks++; if (bus_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_off_data: got %h expected 0", bus_rdata); end
`endif
  endtask

  task automatic test_mid_reset();
    bus_write(2'd1, 32'h1);
    repeat (3) tick();
    n_checks++; if (disp_light !== 1'b1) begin n_fail++; $display("FAIL pre_reset_light: got %b expected 1", disp_light); end
    kb_valid = 1'b1; kb_code = 4'h9;
    rst_n = 1'b0;
    #1;
    n_checks++; if (disp_light !== 1'b0) begin n_fail++; $display("FAIL mid_reset_light: got %b expected 0", disp_light); end
    n_checks++; if (disp_num !== 32'h0) begin n_fail++; $display("FAIL mid_reset_num: got %h expected 0", disp_num); end
    n_checks++; if (kb_ready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_kb_ready: got %b expected 0", kb_ready); end
    n_checks++; if (scan_clk !== 1'b0) begin n_fail++; $display("FAIL mid_reset_scan: got %b expected 0", scan_clk); end
    n_checks++; if (bus_rdata !== 32'h0) begin n_fail++; $display("FAIL mid_reset_rdata: got %h expected 0", bus_rdata); end
    repeat (2) tick();
    rst_n = 1'b1;
    bus_re = 1'b1; bus_addr = 2'd1;
    tick();
    bus_re = 1'b0;
    n_checks++; if (bus_rdata !== 32'h0) begin n_fail++; $display("FAIL post_reset_ctrl: got %h expected 0", bus_rdata); end
    n_checks++; if (disp_num !== 32'h0) begin n_fail++; $display("FAIL pending_not_taken: got %h expected 0", disp_num); end
    bus_write(2'd1, 32'h4);
    #1;
    n_checks++; if (kb_ready !== 1'b1) begin n_fail++; $display("FAIL pending_ready: got %b expected 1", kb_ready); end
    tick();
    kb_valid = 1'b0;
    n_checks++; if (disp_num !== 32'h9) begin n_fail++; $display("FAIL pending_taken: got %h expected 00000009", disp_num); end
  endtask

  initial begin
    test_reset();
    test_data_en();
    test_blink();
    test_kb();
    test_collision();
    test_random();
    test_readback();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
